// File: rtl/bd8_pkg.sv
// Shared encodings and default timing for the BD8 flash arbiter.
package bd8_pkg;

    // OWNER output and FSM state share one encoding.
    typedef enum logic [1:0] {
        OWNER_IDLE  = 2'b00,
        OWNER_EMU   = 2'b01,
        OWNER_MPSSE = 2'b10,
        OWNER_GAP   = 2'b11
    } owner_e;

    localparam int DEF_TURNAROUND   = 8;
    localparam int DEF_IDLE_TIMEOUT = 48000;
    localparam int DEF_SYNC_STAGES  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bd8_sync.sv
// Multi-flop synchroniser for single-bit control signals arriving from another clock domain.
module bd8_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            // NOTE: non-blocking, so each stage captures its neighbour's pre-edge value.
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bd8_flash_arbiter.sv
// Shares one SPI flash between the emulator core and the FT232 MPSSE host.
// The registered owner drives a combinational pin mux; a deselect gap separates owners.
module bd8_flash_arbiter
    import bd8_pkg::*;
#(
    parameter int TURNAROUND   = DEF_TURNAROUND,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic       MCLK,
    input  logic       nRESET,
    input  logic       PWRSTAT,
    input  logic       nEMU_REQ,
    output logic       nEMU_GNT,
    input  logic       EMU_nCS,
    input  logic       EMU_MOSI,
    input  logic       EMU_CLK,
    output logic       EMU_MISO,
    input  logic       nMPSSE_REQ,
    output logic       nMPSSE_GNT,
    input  logic       MPSSE_nCS,
    input  logic       MPSSE_MOSI,
    input  logic       MPSSE_CLK,
    output logic       MPSSE_MISO,
    output logic       nROMCS,
    output logic       ROMMOSI,
    output logic       ROMCLK,
    input  logic       ROMMISO,
    output logic       nWP,
    output logic [1:0] OWNER,
    output logic       TIMEOUT_FLAG
);

    localparam int CNT_MAX = max_int(TURNAROUND, IDLE_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    owner_e           state;
    owner_e           state_nx;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_nx;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_nx;
    logic             revoke;
    logic             mpsse_req_n_s;
    logic             mpsse_ncs_s;
    logic             emu_wait;
    logic             mpsse_wait;

    bd8_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_req (
        .MCLK   (MCLK),
        .nRESET (nRESET),
        .d      (nMPSSE_REQ),
        .q      (mpsse_req_n_s)
    );

    bd8_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .MCLK   (MCLK),
        .nRESET (nRESET),
        .d      (MPSSE_nCS),
        .q      (mpsse_ncs_s)
    );

    assign emu_wait   = ~nEMU_REQ;
    assign mpsse_wait = ~mpsse_req_n_s;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nx    = state;
        gap_cnt_nx  = '0;
        idle_cnt_nx = '0;
        revoke      = 1'b0;
        case (state)
            OWNER_IDLE: begin
                if (emu_wait && mpsse_wait) begin
                    state_nx = PWRSTAT ? OWNER_MPSSE : OWNER_EMU;
                end else if (emu_wait) begin
                    state_nx = OWNER_EMU;
                end else if (mpsse_wait) begin
                    state_nx = OWNER_MPSSE;
                end
            end
            OWNER_EMU: begin
                // A dropped request only takes effect once the current frame has ended.
                if (!emu_wait && EMU_nCS) begin
                    state_nx = OWNER_GAP;
                end
            end
            OWNER_MPSSE: begin
                if (!mpsse_wait && mpsse_ncs_s) begin
                    state_nx = OWNER_GAP;
                end else if (mpsse_ncs_s && emu_wait) begin
                    // Stalled host between frames while the emulator waits: count towards revoke.
                    if (idle_cnt >= IDLE_LAST) begin
                        state_nx = OWNER_GAP;
                        revoke   = 1'b1;
                    end else begin
                        idle_cnt_nx = idle_cnt + 1'b1;
                    end
                end
            end
            OWNER_GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    state_nx = OWNER_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = OWNER_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state        <= OWNER_IDLE;
            gap_cnt      <= '0;
            idle_cnt     <= '0;
            TIMEOUT_FLAG <= 1'b0;
            nEMU_GNT     <= 1'b1;
            nMPSSE_GNT   <= 1'b1;
            nWP          <= 1'b0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_cnt_nx;
            idle_cnt   <= idle_cnt_nx;
            nEMU_GNT   <= (state_nx != OWNER_EMU);
            nMPSSE_GNT <= (state_nx != OWNER_MPSSE);
            nWP        <= (state_nx == OWNER_MPSSE);
            if (revoke) begin
                TIMEOUT_FLAG <= 1'b1;
            end
        end
    end

    assign OWNER = state;

    // Mux select is the registered owner only; MPSSE data lines pass through unsynchronised.
    always_comb begin
        nROMCS     = 1'b1;
        ROMCLK     = 1'b0;
        ROMMOSI    = 1'b0;
        EMU_MISO   = 1'b0;
        MPSSE_MISO = 1'b0;
        case (state)
            OWNER_EMU: begin
                nROMCS   = EMU_nCS;
                ROMCLK   = EMU_CLK;
                ROMMOSI  = EMU_MOSI;
                EMU_MISO = ROMMISO;
            end
            OWNER_MPSSE: begin
                nROMCS     = MPSSE_nCS;
                ROMCLK     = MPSSE_CLK;
                ROMMOSI    = MPSSE_MOSI;
                MPSSE_MISO = ROMMISO;
            end
            default: ;
        endcase
    end

endmodule
